fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage integer pipeline. It keeps a shadow copy of the destination-register information for instructions in EX, MEM and WB. For each instruction leaving ID it decides whether ALU operand A and ALU operand B take a forwarded value, and from which stage. It also sequences load-use stalls and branch flushes, driving the forward enables and selects of the ALU A/B operand muxes one cycle after the decision is made.

## Interface
Parameters:
- REG_ADDR_W, 4, width of a register address.
- ZERO_REG, 1, if 1 then register address 0 is hard-wired and never matches for forwarding or stalls.

Ports:
- clk, input, 1, pipeline clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- hold, input, 1, global freeze from memory; all state and registered outputs keep their values.
- flush, input, 1, branch taken; the instruction in ID is squashed.
- id_valid, input, 1, the ID stage holds a real instruction.
- id_rs_a, input, REG_ADDR_W, source register for operand A.
- id_rs_b, input, REG_ADDR_W, source register for operand B.
- id_use_a, input, 1, the ID instruction reads rs_a.
- id_alu_b_op, input, `ALU_B_OP_BUS, operand B source: `ALU_B_OP_IM or `ALU_B_OP_REGB.
- id_wr_en, input, 1, the ID instruction writes a register.
- id_dst, input, REG_ADDR_W, destination register of the ID instruction.
- id_is_load, input, 1, the ID instruction is a load.
- stall, output, 1, hold PC, IF/ID and ID; combinational.
- bubble, output, 1, write a NOP into ID/EX this cycle; combinational.
- alu_a_fowd_en, output, 1, registered; the EX stage uses a forwarded value for operand A.
- alu_a_fowd_sel, output, 1, registered; 0 = from the EX/MEM result, 1 = from the MEM/WB result.
- alu_b_fowd_en, output, 1, registered; feeds ALU_B_FOWD_en of the operand B mux.
- alu_b_fowd_sel, output, 1, registered; same encoding as alu_a_fowd_sel.

## Operation
- Shadow pipeline: three entries, ex, mem and wb. Each entry holds {valid, wr, dst, is_load}.
  - On every non-hold edge: wb <= mem, then mem <= ex.
  - ex <= the ID entry only if issuing. Issuing means id_valid & ~stall & ~flush. Otherwise ex <= invalid.
- Match on operand X: id_use_X & src == entry.dst & entry.valid & entry.wr & ~(ZERO_REG & src == 0).
- Operand B is considered only when id_alu_b_op == `ALU_B_OP_REGB. With `ALU_B_OP_IM, alu_b_fowd_en is always 0.
- Forward decision is computed in ID and registered at the ID/EX edge:
  - A match on the current ex entry gives en=1, sel=0.
  - Otherwise a match on the current mem entry gives en=1, sel=1.
  - Otherwise en=0, sel=0.
  - The ex entry wins over the mem entry, because it is the younger writer.
- Load-use hazard: the ex entry has is_load and matches operand A or operand B.
- FSM with two states:
  - RUN: a load-use hazard with ~flush drives stall=1 and bubble=1, and the FSM moves to LU_STALL. Otherwise stall=0.
  - LU_STALL: stall=0. The load is now in the mem entry, so the forward select resolves to sel=1. The FSM returns to RUN unconditionally. A new hazard is re-evaluated in RUN on the next cycle.
- Registered forward outputs when the ID/EX slot is not issuing (stall, flush or ~id_valid): 0.
- Simultaneous events, in priority order: hold, then flush, then stall.
  - flush during a load-use hazard: no stall. A bubble is inserted and the FSM stays in RUN.
  - hold: the FSM, the shadow entries and the outputs are all frozen. stall and bubble are forced to 0.

## Timing
- Reset (rst_n low): all shadow entries invalid, FSM in RUN, and all registered outputs 0.
- Reset assertion mid-stall aborts the stall immediately, because reset is asynchronous.
- Forward outputs have 1-cycle latency: they are valid during the cycle the consumer is in EX.
- stall and bubble are same-cycle combinational functions of the ID inputs and the ex entry. There is no path from the registered outputs into them.
- Load-use costs exactly 1 bubble, and the consumer then receives forwarding from WB.

## Structure
- Shared definitions go into define.v: `ALU_B_OP_BUS, `ALU_B_OP_IM, `ALU_B_OP_REGB, the FSM state encodings (`FHC_RUN, `FHC_LU_STALL) and the forward select encodings (`FOWD_SEL_MEM = 0, `FOWD_SEL_WB = 1).
- One sub-module, fwd_match: combinational compare of one source register against the ex and mem entries. It produces en and sel. It is instantiated once for A and once for B.
- The shadow pipeline, the FSM and the output registers stay in the top module.

## Test plan
- Forward from EX/MEM: issue ADD r1. Next cycle issue ADD with rs_a=r1 and rs_b=r1 (REGB). Required: a_en=1, a_sel=0, b_en=1, b_sel=0 in the consumer's EX cycle, and stall=0.
- Forward from MEM/WB with immediate operand: issue a write to r2, then a NOP, then a consumer with rs_a=r2 and ALU_B_OP_IM. Required: a_en=1, a_sel=1, b_en=0.
- Load-use: issue LW r3, then a consumer with rs_b=r3 (REGB). Required:
  - stall=1 and bubble=1 for exactly 1 cycle.
  - Then b_en=1, b_sel=1.
  - FSM goes RUN, then LU_STALL, then RUN.
- Priority and zero register:
  - Write r4 twice in consecutive instructions, then consume r4. Required: sel=0, from the younger writer.
  - Source r0 with ZERO_REG=1. Required: en=0 and no stall.
- Flush during hazard: LW r5, then a consumer of r5 with flush=1 in the same cycle. Required: stall=0, bubble=1, and all fowd_en=0 next cycle.
- Hold and reset:
  - Assert hold mid-sequence for 3 cycles. Required: outputs and shadow entries unchanged.
  - Assert rst_n=0 while in LU_STALL. Required: all outputs 0 and the FSM in RUN, asynchronously.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg : shared encodings for the forwarding/hazard controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fwd_hazard_ctrl_pkg;

    localparam int ALU_B_OP_W = 1;
    localparam logic [ALU_B_OP_W-1:0] ALU_B_OP_IM   = 1'b0;
    localparam logic [ALU_B_OP_W-1:0] ALU_B_OP_REGB = 1'b1;

    localparam logic FOWD_SEL_MEM = 1'b0;
    localparam logic FOWD_SEL_WB  = 1'b1;

    typedef enum logic [0:0] {
        FHC_RUN      = 1'b0,
        FHC_LU_STALL = 1'b1
    } fhc_state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match : compares one source register against the ex and mem entries
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                  use_src,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  ex_valid,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  mem_valid,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  en,
    output logic                  sel,
    output logic                  ex_hit
);

    logic w_src_live;
    logic w_mem_hit;

    assign w_src_live = use_src & ~((ZERO_REG != 0) && (src == '0));
    assign ex_hit     = w_src_live & ex_valid  & ex_wr  & (ex_dst  == src);
    assign w_mem_hit  = w_src_live & mem_valid & mem_wr & (mem_dst == src);

    // The ex entry is the younger writer, so it shadows the mem entry.
    assign en  = ex_hit | w_mem_hit;
    assign sel = ex_hit ? FOWD_SEL_MEM : (w_mem_hit ? FOWD_SEL_WB : FOWD_SEL_MEM);

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl : operand forwarding, load-use stall and flush sequencing
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic                  id_use_a,
    input  logic [ALU_B_OP_W-1:0] id_alu_b_op,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_is_load,
    output logic                  stall,
    output logic                  bubble,
    output logic                  alu_a_fowd_en,
    output logic                  alu_a_fowd_sel,
    output logic                  alu_b_fowd_en,
    output logic                  alu_b_fowd_sel
);

    // The entry leaving mem needs no tracking: its register-file write
    // completes before any instruction in ID reads its operands.
    logic                  r_ex_valid, r_ex_wr, r_ex_load;
    logic [REG_ADDR_W-1:0] r_ex_dst;
    logic                  r_mem_valid, r_mem_wr;
    logic [REG_ADDR_W-1:0] r_mem_dst;

    fhc_state_t r_state;
    fhc_state_t w_state_next;

    logic w_use_b;
    logic w_a_en, w_a_sel, w_a_ex_hit;
    logic w_b_en, w_b_sel, w_b_ex_hit;
    logic w_hazard;
    logic w_issue;

    assign w_use_b = (id_alu_b_op == ALU_B_OP_REGB);

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_match_a (
        .use_src  (id_use_a),
        .src      (id_rs_a),
        .ex_valid (r_ex_valid),
        .ex_wr    (r_ex_wr),
        .ex_dst   (r_ex_dst),
        .mem_valid(r_mem_valid),
        .mem_wr   (r_mem_wr),
        .mem_dst  (r_mem_dst),
        .en       (w_a_en),
        .sel      (w_a_sel),
        .ex_hit   (w_a_ex_hit)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_match_b (
        .use_src  (w_use_b),
        .src      (id_rs_b),
        .ex_valid (r_ex_valid),
        .ex_wr    (r_ex_wr),
        .ex_dst   (r_ex_dst),
        .mem_valid(r_mem_valid),
        .mem_wr   (r_mem_wr),
        .mem_dst  (r_mem_dst),
        .en       (w_b_en),
        .sel      (w_b_sel),
        .ex_hit   (w_b_ex_hit)
    );

    // An empty ID slot has nothing to stall for.
    assign w_hazard = id_valid & r_ex_load & (w_a_ex_hit | w_b_ex_hit);

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        bubble       = 1'b0;
        if (!hold) begin
            case (r_state)
                FHC_RUN: begin
                    if (w_hazard) begin
                        bubble = 1'b1;
                        if (!flush) begin
                            stall        = 1'b1;
                            w_state_next = FHC_LU_STALL;
                        end
                    end
                end
                FHC_LU_STALL: w_state_next = FHC_RUN;
                default:      w_state_next = FHC_RUN;
            endcase
        end
    end

    assign w_issue = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= FHC_RUN;
            r_ex_valid     <= 1'b0;
            r_ex_wr        <= 1'b0;
            r_ex_load      <= 1'b0;
            r_ex_dst       <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_dst      <= '0;
            alu_a_fowd_en  <= 1'b0;
            alu_a_fowd_sel <= 1'b0;
            alu_b_fowd_en  <= 1'b0;
            alu_b_fowd_sel <= 1'b0;
        end else if (!hold) begin
            r_state        <= w_state_next;
            r_mem_valid    <= r_ex_valid;
            r_mem_wr       <= r_ex_wr;
            r_mem_dst      <= r_ex_dst;
            r_ex_valid     <= w_issue;
            r_ex_wr        <= w_issue & id_wr_en;
            r_ex_load      <= w_issue & id_is_load;
            r_ex_dst       <= w_issue ? id_dst : '0;
            alu_a_fowd_en  <= w_issue & w_a_en;
            alu_a_fowd_sel <= w_issue & w_a_sel;
            alu_b_fowd_en  <= w_issue & w_b_en;
            alu_b_fowd_sel <= w_issue & w_b_sel;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl : directed and random checks against a reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_ctrl;
    import fwd_hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [3:0] id_rs_a = '0, id_rs_b = '0, id_dst = '0;
    logic       id_use_a = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
    logic [ALU_B_OP_W-1:0] id_alu_b_op = ALU_B_OP_IM;
    logic       stall, bubble;
    logic       alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel;

    fwd_hazard_ctrl #(.REG_ADDR_W(4), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_use_a(id_use_a), .id_alu_b_op(id_alu_b_op), .id_wr_en(id_wr_en),
        .id_dst(id_dst), .id_is_load(id_is_load),
        .stall(stall), .bubble(bubble),
        .alu_a_fowd_en(alu_a_fowd_en), .alu_a_fowd_sel(alu_a_fowd_sel),
        .alu_b_fowd_en(alu_b_fowd_en), .alu_b_fowd_sel(alu_b_fowd_sel)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: the two youngest in-flight writers, youngest first.
    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [3:0] dst;
    } ent_t;

    ent_t       in_flight [2];
    logic       m_stalled;
    logic [3:0] m_out;   // {a_en, a_sel, b_en, b_sel}
    logic       e_stall, e_bubble;

    function automatic logic reads(ent_t e, logic u, logic [3:0] s);
        return u && e.v && e.wr && (e.dst == s) && (s != 4'd0);
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_flight[0] = '0;
        in_flight[1] = '0;
        m_stalled = 1'b0;
        m_out = '0;
    endtask

    function automatic logic [1:0] pick(logic u, logic [3:0] s);
        for (int k = 0; k < 2; k++)
            if (reads(in_flight[k], u, s)) return {1'b1, (k == 1)};
        return 2'b00;
    endfunction

    task automatic cyc();
        logic use_b, hz, issue;
        #1;
        use_b = (id_alu_b_op == ALU_B_OP_REGB);
        hz = id_valid && in_flight[0].ld &&
             (reads(in_flight[0], id_use_a, id_rs_a) || reads(in_flight[0], use_b, id_rs_b));
        e_bubble = !hold && !m_stalled && hz;
        e_stall  = e_bubble && !flush;
        chk("stall",  {3'b0, stall},  {3'b0, e_stall});
        chk("bubble", {3'b0, bubble}, {3'b0, e_bubble});
        @(posedge clk);
        if (!hold) begin
            issue = id_valid && !e_stall && !flush;
            m_out = issue ? {pick(id_use_a, id_rs_a), pick(use_b, id_rs_b)} : 4'b0;
            in_flight[1] = in_flight[0];
            in_flight[0] = issue ? '{v: 1'b1, wr: id_wr_en, ld: id_is_load, dst: id_dst} : '0;
            m_stalled = e_stall;
        end
        #1;
        chk("fowd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, m_out);
        chk("state", {3'b0, dut.r_state}, {3'b0, m_stalled ? FHC_LU_STALL : FHC_RUN});
        @(negedge clk);
    endtask

    task automatic instr(input logic v, input logic [3:0] ra, input logic ua,
                         input logic [3:0] rb, input logic regb,
                         input logic wr, input logic [3:0] d, input logic ld);
        id_valid = v; id_rs_a = ra; id_use_a = ua; id_rs_b = rb;
        id_alu_b_op = regb ? ALU_B_OP_REGB : ALU_B_OP_IM;
        id_wr_en = wr; id_dst = d; id_is_load = ld;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_fowd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b0);
        chk("reset_state", {3'b0, dut.r_state}, {3'b0, FHC_RUN});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward from EX/MEM on both operands.
        instr(1, 0, 0, 0, 0, 1, 4'd1, 0); cyc();
        instr(1, 4'd1, 1, 4'd1, 1, 1, 4'd6, 0); cyc();
        chk("exmem_fwd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b1010);

        // Forward from MEM/WB with immediate B.
        instr(1, 0, 0, 0, 0, 1, 4'd2, 0); cyc();
        instr(0, 0, 0, 0, 0, 0, 4'd0, 0); cyc();
        instr(1, 4'd2, 1, 4'd2, 0, 1, 4'd7, 0); cyc();
        chk("memwb_fwd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b1100);

        // Load-use: one stall cycle, then forward from WB.
        instr(1, 0, 0, 0, 0, 1, 4'd3, 1); cyc();
        instr(1, 0, 0, 4'd3, 1, 1, 4'd8, 0); cyc();
        chk("lu_stall_seen", {2'b0, e_stall, e_bubble}, 4'b0011);
        cyc();
        chk("lu_fwd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b0011);

        // Younger writer wins.
        instr(1, 0, 0, 0, 0, 1, 4'd4, 0); cyc();
        instr(1, 0, 0, 0, 0, 1, 4'd4, 0); cyc();
        instr(1, 4'd4, 1, 4'd4, 1, 0, 4'd0, 0); cyc();
        chk("younger", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b1010);

        // r0 never matches, even behind a load to r0.
        instr(1, 0, 0, 0, 0, 1, 4'd0, 1); cyc();
        instr(1, 4'd0, 1, 4'd0, 1, 0, 4'd0, 0); cyc();
        chk("zero_reg", {alu_a_fowd_en, alu_b_fowd_en, e_stall, e_bubble}, 4'b0000);

        // Flush during a load-use hazard.
        instr(1, 0, 0, 0, 0, 1, 4'd5, 1); cyc();
        instr(1, 4'd5, 1, 0, 0, 0, 4'd0, 0); flush = 1'b1; cyc();
        flush = 1'b0;
        chk("flush_hz", {e_stall, e_bubble, alu_a_fowd_en, alu_b_fowd_en}, 4'b0100);

        // Hold for three cycles over a pending hazard.
        instr(1, 0, 0, 0, 0, 1, 4'd7, 1); cyc();
        instr(1, 4'd7, 1, 0, 0, 0, 4'd0, 0); hold = 1'b1;
        repeat (3) cyc();
        hold = 1'b0;
        cyc();
        chk("after_hold", {2'b0, e_stall, e_bubble}, 4'b0011);

        // Asynchronous reset in LU_STALL.
        cyc();
        instr(1, 0, 0, 0, 0, 1, 4'd8, 1); cyc();
        instr(1, 4'd8, 1, 0, 0, 0, 4'd0, 0); cyc();
        chk("in_lu_stall", {3'b0, dut.r_state}, {3'b0, FHC_LU_STALL});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fowd", {alu_a_fowd_en, alu_a_fowd_sel, alu_b_fowd_en, alu_b_fowd_sel}, 4'b0);
        chk("async_rst_state", {3'b0, dut.r_state}, {3'b0, FHC_RUN});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic over a small register window to provoke hits.
        for (int i = 0; i < 400; i++) begin
            instr(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
